// File: rtl/ysyx_22050612_pkg.sv
// Shared encodings for the NPC memory arbiter: FSM states and transaction owner.
package ysyx_22050612_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_WAIT = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050612_rr2.sv
// Two-way round-robin grant: on contention the requester that did not win last time is served.
module ysyx_22050612_rr2
   import ysyx_22050612_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one downstream memory port between IFU and LSU, one transaction in flight at a time.
//
//   state   | meaning
//   --------+---------------------------------------------
//   IDLE    | no transaction; grant and accept requesters
//   REQ     | mem_req_valid high, waiting for mem_req_ready
//   WAIT    | request accepted downstream, awaiting response
//   RESP    | one-cycle response pulse to the owner
module ysyx_22050612_mem_arbiter
   import ysyx_22050612_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic                lsu_wen,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic                busy,
   output logic                proto_err
);

   state_t     state;
   logic       last_grant;
   logic       owner;
   logic [1:0] gnt;
   logic       ifu_fire;
   logic       lsu_fire;

   ysyx_22050612_rr2 u_rr2 (
      .req        ({lsu_req_valid, ifu_req_valid}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   assign ifu_req_ready = (state == ST_IDLE) & gnt[0];
   assign lsu_req_ready = (state == ST_IDLE) & gnt[1];
   assign ifu_fire      = ifu_req_valid & ifu_req_ready;
   assign lsu_fire      = lsu_req_valid & lsu_req_ready;

   // All requester-facing and memory-facing outputs come from registers only.
   assign mem_req_valid = (state == ST_REQ);
   assign busy          = (state != ST_IDLE);
   assign ifu_rsp_valid = (state == ST_RESP) & (owner == OWN_IFU);
   assign lsu_rsp_valid = (state == ST_RESP) & (owner == OWN_LSU);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= OWN_LSU;
         owner      <= OWN_IFU;
         mem_wen    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
         ifu_rdata  <= '0;
         lsu_rdata  <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (mem_rsp_valid && (state != ST_WAIT)) begin
            proto_err <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (ifu_fire) begin
                  owner      <= OWN_IFU;
                  last_grant <= OWN_IFU;
                  mem_wen    <= 1'b0;
                  mem_addr   <= ifu_addr;
                  mem_wdata  <= '0;
                  mem_wmask  <= '0;
                  state      <= ST_REQ;
               end else if (lsu_fire) begin
                  owner      <= OWN_LSU;
                  last_grant <= OWN_LSU;
                  mem_wen    <= lsu_wen;
                  mem_addr   <= lsu_addr;
                  mem_wdata  <= lsu_wdata;
                  mem_wmask  <= lsu_wmask;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Stores return an ack only; whatever is on mem_rdata is discarded.
               if (mem_rsp_valid) begin
                  if (owner == OWN_IFU) begin
                     ifu_rdata <= mem_wen ? '0 : mem_rdata;
                  end else begin
                     lsu_rdata <= mem_wen ? '0 : mem_rdata;
                  end
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios, then random traffic against a transaction-level model.
module tb_ysyx_22050612_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid;
   logic [63:0] ifu_addr = '0, ifu_rdata;
   logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_rsp_valid;
   logic [63:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
   logic [7:0]  lsu_wmask = '0;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_rsp_valid = 1'b0;
   logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [7:0]  mem_wmask;
   logic        busy, proto_err;

   ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one transaction record with handshake/response milestones.
   logic        m_known = 1'b0, m_inflt = 1'b0, m_hs = 1'b0, m_rsp = 1'b0;
   logic        m_own = 1'b0, m_last = 1'b1, m_wen = 1'b0, m_perr = 1'b0;
   logic [63:0] m_addr = '0, m_wdata = '0, m_ifu_rd = '0, m_lsu_rd = '0;
   logic [7:0]  m_wmask = '0;
   int          n_done = 0;

   always @(negedge clk) begin : cmp
      logic e_ifu_rdy, e_lsu_rdy, waiting, resp;
      waiting   = m_inflt && m_hs && !m_rsp;
      resp      = m_inflt && m_rsp;
      e_ifu_rdy = !m_inflt && ifu_req_valid && (!lsu_req_valid || m_last == 1'b1);
      e_lsu_rdy = !m_inflt && lsu_req_valid && (!ifu_req_valid || m_last == 1'b0);
      if (m_known) begin
         chk1("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
         chk1("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
         chk1("mem_req_valid", mem_req_valid, m_inflt && !m_hs);
         chk ("mem_addr", mem_addr, m_addr);
         chk1("mem_wen", mem_wen, m_wen);
         chk ("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
         if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
         chk1("ifu_rsp_valid", ifu_rsp_valid, resp && m_own == 1'b0);
         chk1("lsu_rsp_valid", lsu_rsp_valid, resp && m_own == 1'b1);
         chk ("ifu_rdata", ifu_rdata, m_ifu_rd);
         chk ("lsu_rdata", lsu_rdata, m_lsu_rd);
         chk1("busy", busy, m_inflt);
         chk1("proto_err", proto_err, m_perr);
      end
      if (rst) begin
         m_known = 1'b1; m_inflt = 1'b0; m_hs = 1'b0; m_rsp = 1'b0;
         m_own = 1'b0; m_last = 1'b1; m_wen = 1'b0; m_perr = 1'b0;
         m_addr = '0; m_wdata = '0; m_wmask = '0; m_ifu_rd = '0; m_lsu_rd = '0;
      end else begin
         if (mem_rsp_valid && !waiting) m_perr = 1'b1;
         if (!m_inflt) begin
            if (e_ifu_rdy) begin
               m_inflt = 1'b1; m_hs = 1'b0; m_rsp = 1'b0; m_own = 1'b0; m_last = 1'b0;
               m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            end else if (e_lsu_rdy) begin
               m_inflt = 1'b1; m_hs = 1'b0; m_rsp = 1'b0; m_own = 1'b1; m_last = 1'b1;
               m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
            end
         end else if (!m_hs) begin
            m_hs = mem_req_ready;
         end else if (!m_rsp) begin
            if (mem_rsp_valid) begin
               m_rsp = 1'b1;
               if (m_own == 1'b0) m_ifu_rd = m_wen ? 64'h0 : mem_rdata;
               else               m_lsu_rd = m_wen ? 64'h0 : mem_rdata;
            end
         end else begin
            m_inflt = 1'b0;
            n_done++;
         end
      end
   end

   // Observed handshakes, used to steer stimulus and for directed counts.
   int          cyc = 0, last_ifu_acc = 0, prev_ifu_acc = 0;
   int          n_mem_hs = 0, n_ifu_rsp = 0, n_lsu_rsp = 0;
   logic        f_rst = 1'b0, f_ifu = 1'b0, f_lsu = 1'b0, f_mem = 1'b0;
   logic        p_wen = 1'b0;
   logic [63:0] p_addr = '0, p_wdata = '0;
   logic [7:0]  p_wmask = '0;

   always @(negedge clk) begin
      cyc++;
      f_rst = rst;
      f_ifu = !rst && ifu_req_valid && ifu_req_ready;
      f_lsu = !rst && lsu_req_valid && lsu_req_ready;
      f_mem = !rst && mem_req_valid && mem_req_ready;
      if (f_ifu) begin prev_ifu_acc = last_ifu_acc; last_ifu_acc = cyc; end
      if (f_mem) begin
         n_mem_hs++;
         p_wen = mem_wen; p_addr = mem_addr; p_wdata = mem_wdata; p_wmask = mem_wmask;
      end
      if (ifu_rsp_valid === 1'b1) n_ifu_rsp++;
      if (lsu_rsp_valid === 1'b1) n_lsu_rsp++;
   end

   logic [63:0] mem_arr [logic [63:0]];
   logic        r_pend = 1'b0;
   int          r_cnt = 0;

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : {a[31:0], ~a[31:0]};
   endfunction

   task automatic mem_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] v;
      v = mem_rd(a);
      for (int b = 0; b < 8; b++) if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
      mem_arr[a] = v;
   endtask

   task automatic rand_drive();
      if (f_rst) r_pend = 1'b0;
      rst = ($urandom_range(0, 299) == 0);
      if (!ifu_req_valid || f_ifu) begin
         ifu_req_valid = ($urandom_range(0, 2) == 0);
         ifu_addr      = 64'h8000_0000 + 64'($urandom_range(0, 31)) * 8;
      end
      if (!lsu_req_valid || f_lsu) begin
         lsu_req_valid = ($urandom_range(0, 2) == 0);
         lsu_wen       = 1'($urandom_range(0, 1));
         lsu_addr      = 64'h8000_0000 + 64'($urandom_range(0, 31)) * 8;
         lsu_wdata     = {$urandom, $urandom};
         lsu_wmask     = 8'($urandom);
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = 1'b0;
      if (f_mem) begin r_pend = 1'b1; r_cnt = $urandom_range(0, 3); end
      if (r_pend) begin
         if (r_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = p_wen ? {$urandom, $urandom} : mem_rd(p_addr);
            if (p_wen) mem_wr(p_addr, p_wdata, p_wmask);
            r_pend = 1'b0;
         end else begin
            r_cnt--;
         end
      end
   endtask

   // Called in the REQ cycle with mem_req_ready already set; returns in the RESP cycle.
   task automatic serve_hs(input int rsp_wait, input logic [63:0] data);
      step(); mem_req_ready = 1'b0;
      repeat (rsp_wait) step();
      mem_rsp_valid = 1'b1; mem_rdata = data;
      step(); mem_rsp_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int hs0, r0;
      repeat (2) step();
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk1("rst_mem_wen", mem_wen, 1'b0);
      chk ("rst_mem_addr", mem_addr, 64'h0);
      chk ("rst_mem_wdata", mem_wdata, 64'h0);
      chk ("rst_mem_wmask", 64'(mem_wmask), 64'h0);
      chk ("rst_ifu_rdata", ifu_rdata, 64'h0);
      chk ("rst_lsu_rdata", lsu_rdata, 64'h0);
      chk1("rst_proto_err", proto_err, 1'b0);
      chk1("rst_rsp_valid", ifu_rsp_valid | lsu_rsp_valid, 1'b0);

      // IFU-only fetch with a one-cycle response delay.
      step(); rst = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
      @(negedge clk); chk1("t1_ifu_ready", ifu_req_ready, 1'b1); chk1("t1_lsu_ready", lsu_req_ready, 1'b0);
      step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk); chk1("t1_mem_valid", mem_req_valid, 1'b1); chk("t1_mem_addr", mem_addr, 64'h8000_0000);
      chk1("t1_mem_wen", mem_wen, 1'b0);
      step(); mem_req_ready = 1'b0;
      step(); mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0413_0010_0073;
      step(); mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0004;
      @(negedge clk); chk1("t1_rsp", ifu_rsp_valid, 1'b1); chk("t1_rdata", ifu_rdata, 64'h0000_0413_0010_0073);
      chk1("t1_lsu_rsp", lsu_rsp_valid, 1'b0); chk1("t1_ready_in_resp", ifu_req_ready, 1'b0);
      step();
      @(negedge clk); chk1("t1_ready_again", ifu_req_ready, 1'b1);
      step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      chki("t1_turnaround", last_ifu_acc - prev_ifu_acc, 5);
      serve_hs(0, 64'h1234_5678_9ABC_DEF0);
      @(negedge clk); chk1("t1b_rsp", ifu_rsp_valid, 1'b1); chk("t1b_rdata", ifu_rdata, 64'h1234_5678_9ABC_DEF0);
      step(); chki("t1_ifu_pulses", n_ifu_rsp, 2); chki("t1_lsu_pulses", n_lsu_rsp, 0);

      // LSU store.
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
      lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'hF0;
      @(negedge clk); chk1("t2_lsu_ready", lsu_req_ready, 1'b1);
      step(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk); chk1("t2_mem_wen", mem_wen, 1'b1); chk("t2_mem_addr", mem_addr, 64'h8000_1000);
      chk("t2_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788); chk("t2_mem_wmask", 64'(mem_wmask), 64'hF0);
      serve_hs(0, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk); chk1("t2_rsp", lsu_rsp_valid, 1'b1); chk("t2_rdata", lsu_rdata, 64'h0);
      chk1("t2_ifu_rsp", ifu_rsp_valid, 1'b0);

      // Contention right after reset: IFU, LSU, IFU, LSU.
      step(); rst = 1'b1;
      step(); rst = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
      ifu_addr = 64'h8000_0100; lsu_addr = 64'h8000_2000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1("t3_ifu_gnt", ifu_req_ready, (k % 2) == 0);
         chk1("t3_lsu_gnt", lsu_req_ready, (k % 2) == 1);
         step(); mem_req_ready = 1'b1;
         @(negedge clk); chk("t3_mem_addr", mem_addr, ((k % 2) == 0) ? 64'h8000_0100 : 64'h8000_2000);
         serve_hs(0, 64'(k + 100));
         step();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

      // Backpressure: three cycles without mem_req_ready.
      step(); ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040; hs0 = n_mem_hs;
      step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b0;
      repeat (3) begin
         @(negedge clk); chk1("t4_valid_held", mem_req_valid, 1'b1); chk("t4_addr_held", mem_addr, 64'h8000_0040);
         step();
      end
      mem_req_ready = 1'b1;
      serve_hs(0, 64'h5555_AAAA_5555_AAAA);
      @(negedge clk); chk1("t4_rsp", ifu_rsp_valid, 1'b1);
      step(); chki("t4_one_handshake", n_mem_hs - hs0, 1);

      // Spurious response while idle.
      r0 = n_ifu_rsp + n_lsu_rsp;
      mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      step(); mem_rsp_valid = 1'b0;
      @(negedge clk); chk1("t5_proto_err", proto_err, 1'b1);
      repeat (3) step();
      @(negedge clk); chk1("t5_proto_sticky", proto_err, 1'b1);
      step(); chki("t5_no_rsp", n_ifu_rsp + n_lsu_rsp - r0, 0);

      // Reset while waiting for the response.
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0080;
      step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      step(); mem_req_ready = 1'b0; rst = 1'b1;
      step(); rst = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_00C0; r0 = n_ifu_rsp + n_lsu_rsp;
      @(negedge clk); chk1("t6_busy", busy, 1'b0); chk1("t6_rsp", ifu_rsp_valid, 1'b0);
      chk1("t6_ready", ifu_req_ready, 1'b1); chk1("t6_proto_err", proto_err, 1'b0);
      step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
      serve_hs(1, 64'hCAFE_F00D_0000_0001);
      @(negedge clk); chk1("t6_rsp_after", ifu_rsp_valid, 1'b1); chk("t6_rdata", ifu_rdata, 64'hCAFE_F00D_0000_0001);
      step(); chki("t6_rsp_count", n_ifu_rsp + n_lsu_rsp - r0, 1);

      // Random traffic, occasional resets; model compares every cycle.
      repeat (3000) begin
         rand_drive();
         step();
      end
      rst = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      step(); rst = 1'b0;
      repeat (2) step();
      chk1("rand_progress", n_done > 100, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
# ysyx_22050612_mem_arbiter

Two-requester memory arbiter for the multi-cycle NPC core. It shares a single downstream memory port between the IFU (instruction fetch, read-only) and the LSU (loads and stores). It serialises one outstanding transaction at a time, with round-robin fairness on contention, and routes each response back to the requester that owns the transaction. It sits between the IFU/LSU and the memory model or bus bridge.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; write mask width is DATA_W/8
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  arbiter accepts IFU request this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  one-cycle pulse: ifu_rdata valid
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  arbiter accepts LSU request this cycle
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte-enable for stores
- lsu_rsp_valid  out  1  one-cycle pulse: load data valid or store acknowledged
- lsu_rdata  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  downstream response (read data or write ack)
- mem_rdata  in  DATA_W  downstream read data
- busy  out  1  high in any state other than IDLE
- proto_err  out  1  sticky flag; set on mem_rsp_valid outside WAIT

## Operation
- States:
  - IDLE: no transaction.
  - REQ: mem_req_valid=1.
  - WAIT: awaiting mem_rsp_valid.
  - RESP: response pulse to the owner.
- Grant is computed combinationally in IDLE only.
  - Single requester: that requester is granted.
  - Both requesting: the requester not equal to last_grant is granted.
  - req_ready is high only for the granted requester, and only in IDLE.
- Accept (valid & ready):
  - Latch addr/wen/wdata/wmask and owner.
  - Update last_grant to the owner.
  - Go to REQ.
  - IFU requests latch wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1, with fields driven from the latch and stable until accepted.
  - mem_req_ready=1 → WAIT; otherwise stay in REQ.
- WAIT:
  - mem_rsp_valid=1 → register mem_rdata (forced to 0 if the latched wen=1) and go to RESP.
- RESP:
  - Owner's rsp_valid=1 for exactly one cycle; the other requester's rsp_valid=0.
  - Next state is IDLE.
- rdata outputs hold their last value outside RESP.
- mem_rsp_valid in IDLE/REQ/RESP is ignored for routing and sets proto_err.
- Reset values:
  - State IDLE; last_grant=LSU, so the first contended grant goes to IFU.
  - All valid/ready outputs 0; ifu_rdata, lsu_rdata, mem_* fields 0; busy=0; proto_err=0.
- Reset mid-transaction: returns to IDLE immediately and the in-flight transaction is dropped without a response. Downstream must itself be reset alongside.

## Timing
- Requester accept at cycle t → mem_req_valid from t+1.
- If mem_req_ready at t+1 → WAIT from t+2.
- mem_rsp_valid at cycle w → rsp_valid at w+1 → IDLE at w+2, when a new accept is possible.
- Minimum turnaround, accept-to-accept: 4 cycles, with a zero-wait memory (ready at t+1, rsp at t+2).
- No combinational path from mem_* inputs to requester outputs, or from requester inputs to mem_* outputs.
- req_ready depends combinationally on both req_valid inputs and state only.

## Structure
- Shared package ysyx_22050612_pkg holds:
  - The state enum (IDLE, REQ, WAIT, RESP; 2 bits).
  - The owner encoding (OWN_IFU=0, OWN_LSU=1).
- Sub-module ysyx_22050612_rr2 contains the 2-way round-robin grant logic: inputs req[1:0] and last_grant; output one-hot gnt.
- Everything else lives in one module.

## Test plan
- IFU only:
  - Stimulus: ifu_addr=0x80000000; memory ready at once; rsp 2 cycles later with 0x00000413_00100073.
  - Required: ifu_rsp_valid pulses once with that data; lsu_rsp_valid stays 0; turnaround 5 cycles.
- LSU store:
  - Stimulus: lsu_wen=1, addr=0x80001000, wdata=0x1122334455667788, wmask=0xF0.
  - Required: mem_* carry the identical fields; lsu_rsp_valid pulses with lsu_rdata=0.
- Contention: both requesters assert valid continuously for 4 transactions after reset → grants IFU, LSU, IFU, LSU.
- Backpressure: mem_req_ready held 0 for 3 cycles → mem_req_valid and mem_addr stay stable, then exactly one handshake occurs.
- Spurious response: mem_rsp_valid pulsed in IDLE → proto_err=1 and stays 1; no rsp_valid pulse.
- Reset in WAIT: rst for 1 cycle → next cycle state is IDLE, busy=0, no rsp_valid; a following IFU request completes normally.
